// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// alu_seq_ctrl : sequenced 32-bit ALU with single-cycle logic/arith ops and
//                32-iteration shift-add MUL / restoring DIV on magnitudes.
// Revision 1.0
// ============================================================================
module alu_seq_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero,
  output logic        err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_mul_q, is_mul_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  // MUL: acc = partial product, opa = shifting multiplicand, opb = multiplier.
  // DIV: acc = {remainder, dividend/quotient}, opa[31:0] = divisor.
  logic [63:0] acc_q, acc_d;
  logic [63:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] rem_trial;
  logic        div_ge;
  logic [31:0] rem_next;
  logic [63:0] step_acc;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    mag_a     = a[31] ? (32'd0 - a) : a;
    mag_b     = b[31] ? (32'd0 - b) : b;
    rem_trial = acc_q[63:31];
    div_ge    = (rem_trial >= {1'b0, opa_q[31:0]});
    rem_next  = div_ge ? 32'(rem_trial - {1'b0, opa_q[31:0]}) : rem_trial[31:0];
    if (is_mul_q) begin
      step_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
    end else begin
      step_acc = {rem_next, acc_q[30:0], div_ge};
    end
    prod_fix = neg_q  ? (64'd0 - step_acc)        : step_acc;
    quo_fix  = neg_q  ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
    rem_fix  = rneg_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          case (op)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_NOT: result_d = ~a;
            OP_ADD: result_d = a + b;
            OP_SUB: result_d = a - b;
            OP_MUL: begin
              state_d  = S_ITER;
              cnt_d    = 5'd0;
              is_mul_d = 1'b1;
              neg_d    = a[31] ^ b[31];
              rneg_d   = 1'b0;
              acc_d    = 64'd0;
              opa_d    = {32'd0, mag_a};
              opb_d    = mag_b;
            end
            OP_DIV: begin
              if (b == 32'd0) begin
                lo_d     = 32'hFFFF_FFFF;
                hi_d     = a;
                result_d = 32'hFFFF_FFFF;
                err_d    = 1'b1;
              end else begin
                state_d  = S_ITER;
                cnt_d    = 5'd0;
                is_mul_d = 1'b0;
                neg_d    = a[31] ^ b[31];
                rneg_d   = a[31];
                acc_d    = {32'd0, mag_a};
                opa_d    = {32'd0, mag_b};
                opb_d    = 32'd0;
              end
            end
            default: begin
              result_d = 32'd0;
              err_d    = 1'b1;
            end
          endcase
          zero_d = (result_d == 32'd0);
        end
      end
      S_ITER: begin
        acc_d = step_acc;
        opa_d = is_mul_q ? {opa_q[62:0], 1'b0} : opa_q;
        opb_d = {1'b0, opb_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Sign correction is folded into the edge that enters DONE.
          state_d = S_DONE;
          cnt_d   = 5'd0;
          if (is_mul_q) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          result_d = lo_d;
          zero_d   = (lo_d == 32'd0);
          err_d    = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= 64'd0;
      opa_q    <= 64'd0;
      opb_q    <= 32'd0;
      result_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_seq_ctrl : directed self-checking bench for alu_seq_ctrl.
// Revision 1.0
// ============================================================================
module tb_alu_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op    = 4'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy, done, zero, err;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .lo     (lo),
    .zero   (zero),
    .err    (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an op for one cycle (cycle t); returns positioned in cycle t+1.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle offset from t at which done was seen (capped at 40).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_result"}, result,      32'd0);
    chk({tag, "_hi"},     hi,          32'd0);
    chk({tag, "_lo"},     lo,          32'd0);
    chk({tag, "_zero"},   32'(zero),   32'd0);
    chk({tag, "_err"},    32'(err),    32'd0);
  endtask

  initial begin
    int lat;
    bit saw_done;

    tick(); tick();
    reset = 1'b0;
    chk_cleared("reset");

    // AND: single cycle, result zero
    op = 4'b0000; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; start = 1'b1;
    #1;
    chk("and_busy_t", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("and_done",   32'(done), 32'd1);
    chk("and_busy",   32'(busy), 32'd1);
    chk("and_result", result,    32'h0);
    chk("and_zero",   32'(zero), 32'd1);
    chk("and_err",    32'(err),  32'd0);
    tick();
    chk("and_done_t2", 32'(done), 32'd0);
    chk("and_busy_t2", 32'(busy), 32'd0);

    issue(4'b0011, 32'h7FFFFFFF, 32'h00000001);
    chk("add_done",   32'(done), 32'd1);
    chk("add_result", result,    32'h80000000);
    chk("add_zero",   32'(zero), 32'd0);
    tick();

    issue(4'b0100, 32'h12345678, 32'h12345678);
    chk("sub_result", result,    32'h0);
    chk("sub_zero",   32'(zero), 32'd1);
    tick();

    issue(4'b0010, 32'h0, 32'h12345678);
    chk("not_result", result,    32'hFFFFFFFF);
    chk("not_zero",   32'(zero), 32'd0);
    tick();

    // MUL -3*7 with ignored start pulses and changed operands while iterating
    issue(4'b0101, 32'hFFFFFFFD, 32'h00000007);
    lat = 1;
    while (!done && lat < 40) begin
      start = lat[0];
      op = 4'b0011; a = 32'd0; b = 32'd0;
      tick();
      lat++;
    end
    chk("mul_latency", 32'(lat),   32'd33);
    chk("mul_hi",      hi,         32'hFFFFFFFF);
    chk("mul_lo",      lo,         32'hFFFFFFEB);
    chk("mul_result",  result,     32'hFFFFFFEB);
    chk("mul_err",     32'(err),   32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mul_start_in_done_ignored", 32'(busy), 32'd0);
    chk("mul_result_held", result, 32'hFFFFFFEB);

    issue(4'b0110, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    chk("div_latency", 32'(lat), 32'd33);
    chk("div_lo",      lo,       32'hFFFFFFFD);
    chk("div_hi",      hi,       32'hFFFFFFFF);
    chk("div_result",  result,   32'hFFFFFFFD);
    chk("div_err",     32'(err), 32'd0);
    tick();

    // 100 / -7 = -14 rem 2
    issue(4'b0110, 32'd100, 32'hFFFFFFF9);
    wait_done(lat);
    chk("div2_lo", lo, 32'hFFFFFFF2);
    chk("div2_hi", hi, 32'h00000002);
    tick();

    issue(4'b0110, 32'h00000005, 32'h0);
    chk("div0_done",   32'(done), 32'd1);
    chk("div0_lo",     lo,        32'hFFFFFFFF);
    chk("div0_hi",     hi,        32'h00000005);
    chk("div0_result", result,    32'hFFFFFFFF);
    chk("div0_err",    32'(err),  32'd1);
    tick();

    issue(4'b1010, 32'h11111111, 32'h22222222);
    chk("ill_done",   32'(done), 32'd1);
    chk("ill_result", result,    32'h0);
    chk("ill_zero",   32'(zero), 32'd1);
    chk("ill_err",    32'(err),  32'd1);
    chk("ill_hi",     hi,        32'h00000005);
    chk("ill_lo",     lo,        32'hFFFFFFFF);
    tick();

    issue(4'b0001, 32'h000000F0, 32'h0000000F);
    chk("or_result", result,   32'h000000FF);
    chk("or_err",    32'(err), 32'd0);
    chk("or_hi",     hi,       32'h00000005);
    chk("or_lo",     lo,       32'hFFFFFFFF);
    tick();

    // Reset at iteration 10 (cycle t+11) aborts the MUL
    issue(4'b0101, 32'h00001234, 32'h00005678);
    repeat (10) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("abort");
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    issue(4'b0011, 32'd2, 32'd3);
    chk("post_abort_add", result, 32'h00000005);
    tick();

    // Reset wins over a simultaneous start
    op = 4'b0011; a = 32'd9; b = 32'd9; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_done", 32'(done), 32'd0);
    tick();
    chk("rst_prio_done2", 32'(done),  32'd0);
    chk("rst_prio_result", result,    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
